// File: rtl/board_pkg.sv
// Shared board-level constants and the key FSM state encoding.
//   CLK_FREQ_HZ        : board system clock frequency
//   DEB_MS             : key debounce window in milliseconds
//   DEB_CYCLES_DEFAULT : debounce window expressed in clk cycles
//   key_state_t        : per-key debounce FSM state
package board_pkg;

  localparam int CLK_FREQ_HZ        = 50_000_000;
  localparam int DEB_MS             = 20;
  localparam int DEB_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEB_MS;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    DOWN         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, polarity normalisation, stability
// counter and debounce FSM with registered level and strobe outputs.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   key_raw     : raw key pin, asynchronous to clk
//   key_level   : debounced state, 1 = pressed
//   key_press   : 1-cycle strobe on accepted press
//   key_release : 1-cycle strobe on accepted release
module key_debounce_ch
  import board_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int            CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  // Pin level of a released key; the synchroniser resets to it so that
  // leaving reset never looks like a press edge.
  localparam logic          RELEASED = ACTIVE_LOW;

  logic [1:0]       sync;
  logic             p;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values of the others regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {2{RELEASED}};
    end else begin
      sync <= {sync[0], key_raw};
    end
  end

  // Normalised pressed flag: 1 = pressed for either pin polarity.
  assign p = sync[1] ^ ACTIVE_LOW;

  // Strobes default low every cycle and are set only on the accepting
  // transition, so they are single-cycle by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (p) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!p) begin
            state <= IDLE;            // glitch rejected
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= DOWN;
            cnt       <= '0;
            key_press <= 1'b1;
            key_level <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DOWN: begin
          if (!p) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (p) begin
            state <= DOWN;            // bounce while held, no strobe
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            key_release <= 1'b1;
            key_level   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS asynchronous push-buttons into clean levels and
// one-cycle press/release strobes. Channels are fully independent.
//   clk         : system clock (50 MHz on board)
//   rst_n       : asynchronous active-low reset
//   key_in      : raw key pins, asynchronous to clk
//   key_level   : debounced state per key, 1 = pressed
//   key_press   : 1-cycle strobe per key on accepted press
//   key_release : 1-cycle strobe per key on accepted release
module key_debounce
  import board_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_in[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

endmodule
